// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walking-0 row drive, synchronised active-low column
// sampling, press/release debounce, one key code per press, multi-key flagging.
module keypad_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4,
    localparam int unsigned KW      = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            multi_err
);

    localparam int unsigned DW  = $clog2(SCAN_DIV);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned NW  = $clog2(DEBOUNCE + 1);
    localparam int unsigned LCW = $clog2(COLS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_SCAN      = 2'd0,
        S_DEB_PRESS = 2'd1,
        S_HOLD      = 2'd2,
        S_DEB_REL   = 2'd3
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;
    logic [RW-1:0]   r_row;
    logic [ROWS-1:0] r_row_n;
    logic [RW-1:0]   r_cand_row;
    logic [CW-1:0]   r_cand_col;
    logic [NW-1:0]   r_cnt;
    logic [KW-1:0]   r_key_code;
    logic            r_key_valid;
    logic            r_key_held;
    logic            r_multi_err;

    logic            w_tick;
    logic [COLS-1:0] w_low;
    logic [LCW-1:0]  w_low_cnt;
    logic [CW-1:0]   w_low_col;
    logic            w_one_low;
    logic            w_cand_match;
    logic            w_cand_high;
    logic            w_cnt_last;
    logic [RW-1:0]   w_row_next;
    logic [KW-1:0]   w_cand_code;
    logic            w_advance;

    assign w_tick       = (r_div == DIV_LAST) && en;
    assign w_low        = ~r_sync2;
    assign w_one_low    = (w_low_cnt == LCW'(1));
    assign w_cand_match = w_one_low && (w_low_col == r_cand_col);
    assign w_cand_high  = r_sync2[r_cand_col];
    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_row_next   = (r_row == ROW_LAST) ? RW'(0) : r_row + RW'(1);
    assign w_cand_code  = KW'(r_cand_row) * KW'(COLS) + KW'(r_cand_col);

    // Count low columns and locate the (single) low column
    always_comb begin
        w_low_cnt = LCW'(0);
        w_low_col = CW'(0);
        for (int c = 0; c < int'(COLS); c++) begin
            if (w_low[c]) begin
                w_low_cnt = w_low_cnt + LCW'(1);
                w_low_col = CW'(c);
            end
        end
    end

    // Decide whether this tick moves the scan to the next row
    always_comb begin
        w_advance = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_SCAN:      w_advance = !w_one_low;
                S_DEB_PRESS: w_advance = !w_cand_match;
                S_DEB_REL:   w_advance = w_cand_high && w_cnt_last;
                default:     w_advance = 1'b0;
            endcase
        end
    end

    // Row dwell divider; frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == DIV_LAST) ? DW'(0) : r_div + DW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    // Row index and registered walking-0 row drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_row_n <= ~ROWS'(1);
        end else if (w_advance) begin
            r_row   <= w_row_next;
            r_row_n <= ~(ROWS'(1) << w_row_next);
        end
    end

    // Scan / debounce FSM with registered key outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_multi_err <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_one_low) begin
                            r_cand_row <= r_row;
                            r_cand_col <= w_low_col;
                            r_cnt      <= NW'(1);
                            r_state    <= S_DEB_PRESS;
                        end else if (w_low_cnt != LCW'(0)) begin
                            r_multi_err <= 1'b1;
                        end
                    end
                    S_DEB_PRESS: begin
                        if (w_cand_match) begin
                            if (w_cnt_last) begin
                                r_key_code  <= w_cand_code;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= S_HOLD;
                            end else begin
                                r_cnt <= r_cnt + NW'(1);
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_SCAN;
                        end
                    end
                    S_HOLD: begin
                        if (w_cand_high) begin
                            r_cnt   <= NW'(1);
                            r_state <= S_DEB_REL;
                        end
                    end
                    S_DEB_REL: begin
                        if (w_cand_high) begin
                            if (w_cnt_last) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= S_SCAN;
                            end else begin
                                r_cnt <= r_cnt + NW'(1);
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_err = r_multi_err;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated physical keypad reacts to the row drive,
// and a behavioural scanner model predicts every output cycle by cycle.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    localparam int PH_SCAN  = 0;
    localparam int PH_PRESS = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_REL   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] col_n = 4'hF;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_err;

    int n_vec = 0;
    int n_err = 0;

    // one bit per physical key, index row*COLS+col
    logic [15:0] keys = '0;

    // behavioural model state
    int         m_div, m_row, m_phase, m_crow, m_ccol, m_run, m_code;
    bit         m_valid, m_held, m_merr;
    logic [3:0] m_hist1, m_hist2;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_div = 0; m_row = 0; m_phase = PH_SCAN; m_crow = 0; m_ccol = 0;
        m_run = 0; m_code = 0; m_valid = 0; m_held = 0; m_merr = 0;
        m_hist1 = 4'hF; m_hist2 = 4'hF;
    endfunction

    // advance the model across one rising edge given the pre-edge inputs
    function automatic void model_edge(input bit en_v, input logic [3:0] cn);
        int nlow = 0;
        int lowcol = 0;
        bit tick, adv;
        for (int c = 0; c < COLS; c++)
            if (!m_hist2[c]) begin nlow++; lowcol = c; end
        tick = en_v && (m_div == SCAN_DIV - 1);
        m_valid = 0; m_merr = 0; adv = 0;
        if (tick) begin
            case (m_phase)
                PH_SCAN:
                    if (nlow == 0) adv = 1;
                    else if (nlow == 1) begin
                        m_crow = m_row; m_ccol = lowcol; m_run = 1; m_phase = PH_PRESS;
                    end else begin
                        m_merr = 1; adv = 1;
                    end
                PH_PRESS:
                    if (nlow == 1 && lowcol == m_ccol) begin
                        m_run++;
                        if (m_run == DEBOUNCE) begin
                            m_code = m_crow * COLS + m_ccol; m_valid = 1; m_held = 1;
                            m_run = 0; m_phase = PH_HOLD;
                        end
                    end else begin
                        m_run = 0; adv = 1; m_phase = PH_SCAN;
                    end
                PH_HOLD:
                    if (m_hist2[m_ccol]) begin m_run = 1; m_phase = PH_REL; end
                default:
                    if (m_hist2[m_ccol]) begin
                        m_run++;
                        if (m_run == DEBOUNCE) begin
                            m_held = 0; m_run = 0; adv = 1; m_phase = PH_SCAN;
                        end
                    end else begin
                        m_run = 0; m_phase = PH_HOLD;
                    end
            endcase
        end
        if (adv) m_row = (m_row + 1) % ROWS;
        if (en_v) m_div = (m_div + 1) % SCAN_DIV;
        m_hist2 = m_hist1;
        m_hist1 = cn;
    endfunction

    function automatic logic [3:0] pad_cols();
        logic [3:0] r;
        for (int c = 0; c < COLS; c++) r[c] = !keys[m_row * COLS + c];
        return r;
    endfunction

    function automatic logic [10:0] mdl_vec();
        logic [3:0] rn;
        rn = 4'hF ^ (4'h1 << m_row);
        return {rn, 4'(m_code), m_valid, m_held, m_merr};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {row_n, key_code, key_valid, key_held, multi_err};
    endfunction

    // one clock: keypad responds to the current row, model and DUT both take the edge
    task automatic step();
        col_n = pad_cols();
        if (rst) model_reset();
        else model_edge(en, col_n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] pat;
        rst = 1'b1; en = 1'b1; keys = '0;
        step(); step();
        n_vec++;
        if (dut_vec() !== 11'b1110_0000_000) begin
            n_err++; $display("FAIL reset_values: dut=%b want=%b", dut_vec(), 11'b1110_0000_000);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            pat = 4'hF ^ (4'h1 << (((i + 1) / 4) % 4));
            n_vec++;
            if (row_n !== pat || key_valid !== 1'b0 || multi_err !== 1'b0) begin
                n_err++;
                $display("FAIL idle_scan cyc%0d: row_n=%b kv=%b me=%b want row_n=%b kv=0 me=0",
                         i, row_n, key_valid, multi_err, pat);
            end
        end
    endtask

    task automatic test_press();
        bit seen = 0;
        keys = 16'h1 << 6;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL press_track cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
            if (key_valid === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || key_code !== 4'd6 || key_held !== 1'b1) begin
            n_err++;
            $display("FAIL press_accept: seen=%0d code=%0d held=%b want seen=1 code=6 held=1",
                     seen, key_code, key_held);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec() || row_n !== 4'b1101) begin
                n_err++; $display("FAIL press_hold cyc%0d: dut=%b model=%b want row_n=1101",
                                  i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_release();
        int kv_cnt = 0;
        bit dropped = 0;
        keys = '0;
        for (int i = 0; i < 30 && m_phase != PH_REL; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL rel_bounce_a cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
        keys = 16'h1 << 6;
        for (int i = 0; i < 12; i++) begin
            step();
            if (key_valid === 1'b1) kv_cnt++;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL rel_bounce_b cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (kv_cnt != 0 || key_held !== 1'b1 || row_n !== 4'b1101) begin
            n_err++;
            $display("FAIL rel_bounce_hold: kv=%0d held=%b row_n=%b want kv=0 held=1 row_n=1101",
                     kv_cnt, key_held, row_n);
        end
        keys = '0;
        for (int i = 0; i < 40 && !dropped; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL release_track cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
            if (key_held === 1'b0) dropped = 1;
        end
        n_vec++;
        if (!dropped || row_n !== 4'b1011) begin
            n_err++;
            $display("FAIL release_done: dropped=%0d row_n=%b want dropped=1 row_n=1011", dropped, row_n);
        end
    endtask

    task automatic test_press_bounce();
        int kv_cnt = 0;
        keys = 16'h1 << 1;
        for (int i = 0; i < 40 && m_phase != PH_PRESS; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL pbounce_a cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
        keys = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_valid === 1'b1) kv_cnt++;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL pbounce_b cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (kv_cnt != 0 || key_held !== 1'b0) begin
            n_err++; $display("FAIL pbounce_none: kv=%0d held=%b want kv=0 held=0", kv_cnt, key_held);
        end
    endtask

    task automatic test_multi();
        bit seen = 0;
        keys = (16'h1 << 8) | (16'h1 << 11);
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL multi_track cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
            if (multi_err === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || key_valid !== 1'b0 || row_n !== 4'b0111) begin
            n_err++;
            $display("FAIL multi_pulse: seen=%0d kv=%b row_n=%b want seen=1 kv=0 row_n=0111",
                     seen, key_valid, row_n);
        end
        step();
        n_vec++;
        if (multi_err !== 1'b0) begin
            n_err++; $display("FAIL multi_width: multi_err=%b want 0", multi_err);
        end
        keys = '0;
    endtask

    task automatic test_en_and_rst();
        bit seen = 0;
        logic [3:0] snap;
        keys = 16'h1 << 13;
        for (int i = 0; i < 40 && m_phase != PH_PRESS; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL en_a cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
        en = 1'b0;
        snap = row_n;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec() || row_n !== snap || key_valid !== 1'b0) begin
                n_err++; $display("FAIL en_freeze cyc%0d: dut=%b model=%b frozen row_n=%b",
                                  i, dut_vec(), mdl_vec(), snap);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL en_resume cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
            if (key_valid === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || key_code !== 4'd13) begin
            n_err++; $display("FAIL en_accept: seen=%0d code=%0d want seen=1 code=13", seen, key_code);
        end
        step(); step();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (key_held !== 1'b0 || row_n !== 4'b1110 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: held=%b row_n=%b kv=%b want held=0 row_n=1110 kv=0",
                     key_held, row_n, key_valid);
        end
        model_reset();
        keys = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL post_rst cyc%0d: dut=%b model=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        int seg_len, nk;
        for (int s = 0; s < 40; s++) begin
            keys = '0;
            nk = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++) keys[$urandom_range(0, 15)] = 1'b1;
            seg_len = $urandom_range(3, 50);
            for (int i = 0; i < seg_len; i++) begin
                en = ($urandom_range(0, 7) != 0);
                step();
                n_vec++;
                if (dut_vec() !== mdl_vec()) begin
                    n_err++; $display("FAIL random seg%0d cyc%0d keys=%h: dut=%b model=%b",
                                      s, i, keys, dut_vec(), mdl_vec());
                end
            end
        end
        en = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press();
        test_release();
        test_press_bounce();
        test_multi();
        test_en_and_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
